// File: rtl/rv32i_types.sv
// Shared types for the mp4 memory subsystem: cache line geometry and the
// line arbiter's state and grant encodings.
package rv32i_types;

  // Width of one cache line, shared by both caches and the line arbiter.
  localparam int unsigned CACHE_LINE_W = 256;

  // Byte-offset bits inside one line (32-byte lines).
  localparam int unsigned LINE_OFFSET_W = 5;

  // Line arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  // Which cache received the most recent grant.
  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/line_arbiter.sv
// Two-to-one arbiter merging icache and dcache line misses onto the single
// line port of the cacheline adaptor. A grant is held for one whole line
// transaction; simultaneous requests alternate, so neither cache starves.
module line_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned LINE_W = CACHE_LINE_W,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              icache_pmem_read,
  input  logic [ADDR_W-1:0] icache_pmem_address,
  output logic [LINE_W-1:0] icache_pmem_rdata,
  output logic              icache_pmem_resp,

  input  logic              dcache_pmem_read,
  input  logic              dcache_pmem_write,
  input  logic [ADDR_W-1:0] dcache_pmem_address,
  input  logic [LINE_W-1:0] dcache_pmem_wdata,
  output logic [LINE_W-1:0] dcache_pmem_rdata,
  output logic              dcache_pmem_resp,

  output logic              line_read,
  output logic              line_write,
  output logic [ADDR_W-1:0] line_address,
  output logic [LINE_W-1:0] line_wdata,
  input  logic [LINE_W-1:0] line_rdata,
  input  logic              line_resp
);

  // Clears the byte-offset bits so the adaptor always sees a line address.
  localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((1 << LINE_OFFSET_W) - 1);

  arb_state_t        state;
  grant_t            last_grant;
  logic              req_rd;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [LINE_W-1:0] req_wdata;

  logic dcache_req;
  logic grant_d;

  assign dcache_req = dcache_pmem_read | dcache_pmem_write;

  // Pick the winner for a grant taken in IDLE: a lone requester wins,
  // a tie goes to the cache that was not served last.
  always_comb begin
    // NOTE: default assignment first, so no path through the block leaves
    // grant_d unassigned and a latch cannot be inferred.
    grant_d = 1'b0;
    if (dcache_req && !icache_pmem_read) begin
      grant_d = 1'b1;
    end else if (dcache_req && icache_pmem_read) begin
      grant_d = (last_grant == GRANT_I);
    end
  end

  // Arbitration FSM and request capture; the line-side outputs are these
  // registers, so they are glitch-free and drop at once on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
      req_rd     <= 1'b0;
      req_wr     <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register here updates from
      // the values present before this edge regardless of statement order.
      case (state)
        IDLE: begin
          if (icache_pmem_read || dcache_req) begin
            if (grant_d) begin
              // A dcache read+write together is a protocol error; the
              // write-back wins so dirty data is never lost.
              req_wr     <= dcache_pmem_write;
              req_rd     <= ~dcache_pmem_write;
              req_addr   <= dcache_pmem_address & ~OFFSET_MASK;
              req_wdata  <= dcache_pmem_wdata;
              last_grant <= GRANT_D;
              state      <= SERVE_D;
            end else begin
              req_rd     <= 1'b1;
              req_wr     <= 1'b0;
              req_addr   <= icache_pmem_address & ~OFFSET_MASK;
              req_wdata  <= '0;
              last_grant <= GRANT_I;
              state      <= SERVE_I;
            end
          end
        end
        SERVE_I, SERVE_D: begin
          // Cache inputs are ignored here; only the adaptor ends the grant.
          if (line_resp) begin
            req_rd    <= 1'b0;
            req_wr    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            state     <= DONE;
          end
        end
        DONE: begin
          // One idle cycle lets the served cache drop its request before
          // the next arbitration, so a stale request is never re-granted.
          req_rd    <= 1'b0;
          req_wr    <= 1'b0;
          req_addr  <= '0;
          req_wdata <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign line_read    = req_rd;
  assign line_write   = req_wr;
  assign line_address = req_addr;
  assign line_wdata   = req_wdata;

  // Completion is passed straight through to the granted cache only.
  assign icache_pmem_resp = line_resp && (state == SERVE_I);
  assign dcache_pmem_resp = line_resp && (state == SERVE_D);

  // Both caches see the fill data; each qualifies it with its own resp.
  assign icache_pmem_rdata = line_rdata;
  assign dcache_pmem_rdata = line_rdata;

endmodule

// File: tb/tb_line_arbiter.sv
// Self-checking bench for line_arbiter: cache models issue directed line
// requests, an adaptor model answers them, and a scoreboard of expected
// grants is compared against every request the adaptor sees.
module tb_line_arbiter;
  import rv32i_types::*;

  localparam int unsigned LW = 256;
  localparam int unsigned AW = 32;

  logic          clk;
  logic          rst;
  logic          icache_pmem_read;
  logic [AW-1:0] icache_pmem_address;
  logic [LW-1:0] icache_pmem_rdata;
  logic          icache_pmem_resp;
  logic          dcache_pmem_read;
  logic          dcache_pmem_write;
  logic [AW-1:0] dcache_pmem_address;
  logic [LW-1:0] dcache_pmem_wdata;
  logic [LW-1:0] dcache_pmem_rdata;
  logic          dcache_pmem_resp;
  logic          line_read;
  logic          line_write;
  logic [AW-1:0] line_address;
  logic [LW-1:0] line_wdata;
  logic [LW-1:0] line_rdata;
  logic          line_resp;

  line_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .icache_pmem_read    (icache_pmem_read),
    .icache_pmem_address (icache_pmem_address),
    .icache_pmem_rdata   (icache_pmem_rdata),
    .icache_pmem_resp    (icache_pmem_resp),
    .dcache_pmem_read    (dcache_pmem_read),
    .dcache_pmem_write   (dcache_pmem_write),
    .dcache_pmem_address (dcache_pmem_address),
    .dcache_pmem_wdata   (dcache_pmem_wdata),
    .dcache_pmem_rdata   (dcache_pmem_rdata),
    .dcache_pmem_resp    (dcache_pmem_resp),
    .line_read           (line_read),
    .line_write          (line_write),
    .line_address        (line_address),
    .line_wdata          (line_wdata),
    .line_rdata          (line_rdata),
    .line_resp           (line_resp)
  );

  // Expected grant as seen on the line port; gap != 0 means the grant must
  // appear exactly that many cycles after the previous adaptor resp.
  typedef struct {
    bit          is_d;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [LW-1:0] wdata;
    int          gap;
  } exp_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [LW-1:0] wdata;
  } djob_t;

  exp_t        exp_q[$];
  logic [31:0] i_jobs[$];
  djob_t       d_jobs[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_resp_cyc = 0;
  int adapt_delay = 5;
  bit adapt_busy = 0;
  bit i_done = 0;
  bit d_done = 0;

  localparam logic [LW-1:0] RST_PAT = {8{32'hDEAD_BEEF}};
  localparam logic [LW-1:0] A5_PAT  = {32{8'hA5}};
  localparam logic [LW-1:0] PAT_5A  = {32{8'h5A}};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Cache models, sample side: note completion, and abandon everything on reset.
  always @(negedge clk) begin
    #3;
    if (!rst) begin
      i_jobs.delete();
      d_jobs.delete();
      icache_pmem_read  = 1'b0;
      dcache_pmem_read  = 1'b0;
      dcache_pmem_write = 1'b0;
      i_done = 0;
      d_done = 0;
    end else begin
      if (icache_pmem_resp) i_done = 1;
      if (dcache_pmem_resp) d_done = 1;
    end
  end

  // Cache models, drive side: retire a finished job, then present the next.
  always @(posedge clk) begin
    #2;
    if (rst) begin
      if (i_done) begin
        void'(i_jobs.pop_front());
        icache_pmem_read = 1'b0;
        i_done = 0;
      end
      if (i_jobs.size() > 0) begin
        icache_pmem_read    = 1'b1;
        icache_pmem_address = i_jobs[0];
      end
      if (d_done) begin
        void'(d_jobs.pop_front());
        dcache_pmem_read  = 1'b0;
        dcache_pmem_write = 1'b0;
        d_done = 0;
      end
      if (d_jobs.size() > 0) begin
        dcache_pmem_read    = d_jobs[0].rd;
        dcache_pmem_write   = d_jobs[0].wr;
        dcache_pmem_address = d_jobs[0].addr;
        dcache_pmem_wdata   = d_jobs[0].wdata;
      end
    end
  end

  // Adaptor model and monitor: checks each new line request against the
  // scoreboard, answers after adapt_delay cycles, checks the routed resp.
  initial begin
    exp_t e;
    int txn;
    bit aborted;
    logic [LW-1:0] pat;
    txn = 0;
    e = '{is_d: 1'b0, rd: 1'b0, wr: 1'b0, addr: '0, wdata: '0, gap: 0};
    forever begin
      @(negedge clk);
      #1;
      if (rst && (line_read || line_write)) begin
        adapt_busy = 1;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_req: got addr %0h expected no request", line_address);
        end else begin
          e = exp_q.pop_front();
          check("req_read", LW'(line_read), LW'(e.rd));
          check("req_write", LW'(line_write), LW'(e.wr));
          check("req_address", LW'(line_address), LW'(e.addr));
          check("req_wdata", line_wdata, e.wdata);
          if (e.gap != 0) check("grant_gap", LW'(cyc - last_resp_cyc), LW'(e.gap));
        end
        aborted = 0;
        for (int k = 0; k < adapt_delay; k++) begin
          @(negedge clk);
          #1;
          if (!rst) begin
            aborted = 1;
            break;
          end
        end
        if (!aborted) begin
          txn++;
          pat = {8{32'hC0DE_0000 | 32'(txn)}};
          line_rdata = pat;
          line_resp = 1'b1;
          last_resp_cyc = cyc;
          #1;
          check("icache_resp", LW'(icache_pmem_resp), LW'(!e.is_d));
          check("dcache_resp", LW'(dcache_pmem_resp), LW'(e.is_d));
          check("icache_rdata", icache_pmem_rdata, pat);
          check("dcache_rdata", dcache_pmem_rdata, pat);
          @(negedge clk);
          #1;
          line_resp = 1'b0;
        end
        adapt_busy = 0;
      end
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || i_jobs.size() != 0 || d_jobs.size() != 0 || adapt_busy) && n < 400) begin
      @(posedge clk);
      n++;
    end
    tests++;
    if (n >= 400) begin
      fails++;
      $display("FAIL %s_timeout: got %0d pending grants expected 0", name, exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
    check({name, "_idle_state"}, LW'(dut.state), LW'(IDLE));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #4 rst = 1'b0;
    @(posedge clk);
    #4 rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    icache_pmem_read = 1'b0;
    icache_pmem_address = '0;
    dcache_pmem_read = 1'b0;
    dcache_pmem_write = 1'b0;
    dcache_pmem_address = '0;
    dcache_pmem_wdata = '0;
    line_rdata = RST_PAT;
    line_resp = 1'b0;

    // Outputs held low during reset, rdata follows the adaptor.
    #12;
    check("rst_line_read", LW'(line_read), '0);
    check("rst_line_write", LW'(line_write), '0);
    check("rst_line_address", LW'(line_address), '0);
    check("rst_line_wdata", line_wdata, '0);
    check("rst_resps", LW'({icache_pmem_resp, dcache_pmem_resp}), '0);
    check("rst_icache_rdata", icache_pmem_rdata, RST_PAT);
    check("rst_dcache_rdata", dcache_pmem_rdata, RST_PAT);
    @(posedge clk);
    #4 rst = 1'b1;

    // Lone icache read, one cycle of arbitration latency.
    adapt_delay = 5;
    @(posedge clk);
    #1;
    exp_q.push_back('{is_d: 1'b0, rd: 1'b1, wr: 1'b0, addr: 32'h0000_0060, wdata: '0, gap: 0});
    i_jobs.push_back(32'h0000_0064);
    @(negedge clk);
    #1 check("t1_read_cycle0", LW'(line_read), '0);
    @(negedge clk);
    #1 check("t1_read_cycle1", LW'(line_read), LW'(1));
    check("t1_addr_cycle1", LW'(line_address), LW'(32'h0000_0060));
    wait_idle("t1");

    // Tie right after reset: dcache write first, icache at N+3.
    do_reset();
    adapt_delay = 3;
    @(posedge clk);
    #1;
    exp_q.push_back('{is_d: 1'b1, rd: 1'b0, wr: 1'b1, addr: 32'h8000_0020, wdata: A5_PAT, gap: 0});
    exp_q.push_back('{is_d: 1'b0, rd: 1'b1, wr: 1'b0, addr: 32'h0000_0100, wdata: '0, gap: 3});
    d_jobs.push_back('{rd: 1'b0, wr: 1'b1, addr: 32'h8000_0020, wdata: A5_PAT});
    i_jobs.push_back(32'h0000_0100);
    wait_idle("t2");

    // Continuous requests from both caches: D, I, D, I.
    do_reset();
    adapt_delay = 2;
    @(posedge clk);
    #1;
    exp_q.push_back('{is_d: 1'b1, rd: 1'b1, wr: 1'b0, addr: 32'h0000_0200, wdata: '0, gap: 0});
    exp_q.push_back('{is_d: 1'b0, rd: 1'b1, wr: 1'b0, addr: 32'h0000_0300, wdata: '0, gap: 3});
    exp_q.push_back('{is_d: 1'b1, rd: 1'b1, wr: 1'b0, addr: 32'h0000_0240, wdata: '0, gap: 3});
    exp_q.push_back('{is_d: 1'b0, rd: 1'b1, wr: 1'b0, addr: 32'h0000_0340, wdata: '0, gap: 3});
    d_jobs.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h0000_0200, wdata: '0});
    d_jobs.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h0000_0240, wdata: '0});
    i_jobs.push_back(32'h0000_0300);
    i_jobs.push_back(32'h0000_0344);
    wait_idle("t3");

    // Dcache read and write together: only the write reaches the adaptor.
    @(posedge clk);
    #1;
    exp_q.push_back('{is_d: 1'b1, rd: 1'b0, wr: 1'b1, addr: 32'h0000_0400, wdata: PAT_5A, gap: 0});
    d_jobs.push_back('{rd: 1'b1, wr: 1'b1, addr: 32'h0000_041F, wdata: PAT_5A});
    wait_idle("t4");

    // Reset in cycle 3 of an icache transaction, then a tie goes to D.
    adapt_delay = 20;
    @(posedge clk);
    #1;
    exp_q.push_back('{is_d: 1'b0, rd: 1'b1, wr: 1'b0, addr: 32'h0000_0500, wdata: '0, gap: 0});
    i_jobs.push_back(32'h0000_0500);
    repeat (3) @(posedge clk);
    #4 rst = 1'b0;
    line_rdata = RST_PAT;
    #1;
    check("t5_read_dropped", LW'(line_read), '0);
    check("t5_state_idle", LW'(dut.state), LW'(IDLE));
    check("t5_icache_resp", LW'(icache_pmem_resp), '0);
    check("t5_rdata_follow", icache_pmem_rdata, RST_PAT);
    @(posedge clk);
    #4 rst = 1'b1;
    adapt_delay = 2;
    @(posedge clk);
    #1;
    exp_q.push_back('{is_d: 1'b1, rd: 1'b1, wr: 1'b0, addr: 32'h0000_0600, wdata: '0, gap: 0});
    exp_q.push_back('{is_d: 1'b0, rd: 1'b1, wr: 1'b0, addr: 32'h0000_0700, wdata: '0, gap: 3});
    d_jobs.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h0000_0600, wdata: '0});
    i_jobs.push_back(32'h0000_0700);
    wait_idle("t5");

    // Spurious adaptor resp while IDLE is ignored.
    @(negedge clk);
    #1 line_resp = 1'b1;
    #1;
    check("t6_icache_resp", LW'(icache_pmem_resp), '0);
    check("t6_dcache_resp", LW'(dcache_pmem_resp), '0);
    @(posedge clk);
    #1 check("t6_state", LW'(dut.state), LW'(IDLE));
    @(negedge clk);
    #1 line_resp = 1'b0;
    check("t6_line_read", LW'(line_read), '0);
    check("t6_state_after", LW'(dut.state), LW'(IDLE));

    check("scoreboard_empty", LW'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
